// File: rtl/alu_cmd_issue.sv
// Command queue and issue stage feeding the 8-bit combinational ALU.
// Optional macro ALU_ISSUE_BYPASS_EN lets a command arriving at an idle, empty queue skip the FIFO.
module alu_cmd_issue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [2:0]    cmd_opcode,
  input  logic [7:0]    cmd_a,
  input  logic [7:0]    cmd_b,
  input  logic          cmd_acc,
  output logic [7:0]    alu_a,
  output logic [7:0]    alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [7:0]    alu_result,
  input  logic          alu_carry,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [7:0]    rsp_result,
  output logic          rsp_carry,
  output logic          rsp_zero,
  output logic [7:0]    acc,
  output logic [CW-1:0] count
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  typedef struct packed {
    logic [2:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic       acc_sel;
  } cmd_t;

  cmd_t          mem [DEPTH];
  cmd_t          wr_cmd;
  cmd_t          rd_cmd;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] count_nxt;
  logic          push;
  logic          wr_en;
  logic          pop;
  logic          bypass;

  // cmd_ready is a register derived from occupancy only, so a pop never frees a slot the same cycle
  assign push   = cmd_valid && cmd_ready;
  assign wr_en  = push && !bypass;
  assign wr_cmd = {cmd_opcode, cmd_a, cmd_b, cmd_acc};
  assign rd_cmd = mem[rd_ptr];

  // Issue sequencing: pop in IDLE or on a HOLD handshake, ISSUE always lasts one cycle
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    bypass    = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
`ifdef ALU_ISSUE_BYPASS_EN
        else if (push) begin
          bypass    = 1'b1;
          state_nxt = ISSUE;
        end
`endif
      end
      ISSUE: state_nxt = HOLD;
      HOLD: begin
        if (rsp_ready) begin
          if (count != '0) begin
            pop       = 1'b1;
            state_nxt = ISSUE;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (wr_en && !pop) begin
      count_nxt = count + CW'(1);
    end else if (!wr_en && pop) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Queue pointers, occupancy and the registered ready flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cmd_ready <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count     <= count_nxt;
      cmd_ready <= (count_nxt < CW'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_cmd;
    end
  end

  // Issue registers; acc is already updated from the previous ISSUE when a chained pop reads it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= 3'b000;
    end else if (pop) begin
      alu_a      <= rd_cmd.acc_sel ? acc : rd_cmd.a;
      alu_b      <= rd_cmd.b;
      alu_opcode <= rd_cmd.opcode;
    end else if (bypass) begin
      alu_a      <= cmd_acc ? acc : cmd_a;
      alu_b      <= cmd_b;
      alu_opcode <= cmd_opcode;
    end
  end

  // Response capture at the end of ISSUE, released by the consumer handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid  <= 1'b0;
      rsp_result <= 8'h00;
      rsp_carry  <= 1'b0;
      rsp_zero   <= 1'b0;
      acc        <= 8'h00;
    end else if (state == ISSUE) begin
      rsp_valid  <= 1'b1;
      rsp_result <= alu_result;
      rsp_carry  <= alu_carry;
      rsp_zero   <= (alu_result == 8'h00);
      acc        <= alu_result;
    end else if ((state == HOLD) && rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Directed testbench for alu_cmd_issue with a small ALU stub (ADD, XOR, INC).
module tb_alu_cmd_issue;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       cmd_acc;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [2:0] alu_opcode;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;
  logic [7:0] acc;
  logic [2:0] count;
  logic [8:0] alu_res9;

  int chk_total = 0;
  int chk_pass  = 0;

  alu_cmd_issue #(.DEPTH(4), .CW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opcode (cmd_opcode),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_acc    (cmd_acc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .acc        (acc),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub; opcodes not used by the bench return zero
  always_comb begin
    alu_res9 = 9'h000;
    case (alu_opcode)
      3'b000:  alu_res9 = {1'b0, alu_a} + {1'b0, alu_b};
      3'b100:  alu_res9 = {1'b0, alu_a ^ alu_b};
      3'b110:  alu_res9 = {1'b0, alu_a} + 9'd1;
      default: alu_res9 = 9'h000;
    endcase
  end
  assign alu_result = alu_res9[7:0];
  assign alu_carry  = alu_res9[8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic accf);
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_acc    = accf;
    cmd_valid  = 1'b1;
    tick();
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_opcode = 3'b000; cmd_a = 8'h00; cmd_b = 8'h00; cmd_acc = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    chk_total++;
    if ({alu_a, alu_b, alu_opcode, acc, rsp_result, rsp_carry, rsp_zero, rsp_valid} !== 38'h0)
      $display("FAIL reset_regs got %h exp 0",
               {alu_a, alu_b, alu_opcode, acc, rsp_result, rsp_carry, rsp_zero, rsp_valid});
    else chk_pass++;
    chk_total++;
    if (count !== 3'd0) $display("FAIL reset_count got %0d exp 0", count); else chk_pass++;
    chk_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b exp 1", cmd_ready); else chk_pass++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add;
    int n;
    int exp_lat;
`ifdef ALU_ISSUE_BYPASS_EN
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    rsp_ready = 1'b1;
    push(3'b000, 8'hD7, 8'h41, 1'b0);
    wait_rsp(n);
    chk_total++;
    if (n !== exp_lat) $display("FAIL add_latency got %0d exp %0d", n, exp_lat); else chk_pass++;
    chk_total++;
    if ({alu_opcode, alu_a, alu_b} !== {3'b000, 8'hD7, 8'h41})
      $display("FAIL add_issue got %h exp %h", {alu_opcode, alu_a, alu_b}, {3'b000, 8'hD7, 8'h41});
    else chk_pass++;
    chk_total++;
    if ({rsp_result, rsp_carry, rsp_zero} !== {8'h18, 1'b1, 1'b0})
      $display("FAIL add_rsp got %h exp %h", {rsp_result, rsp_carry, rsp_zero}, {8'h18, 1'b1, 1'b0});
    else chk_pass++;
    tick();
    chk_total++;
    if (rsp_valid !== 1'b0) $display("FAIL add_rsp_drop got %b exp 0", rsp_valid); else chk_pass++;
  endtask

  task automatic test_chain;
    int n;
    rsp_ready = 1'b1;
    push(3'b000, 8'h05, 8'h03, 1'b0);
    push(3'b110, 8'hFF, 8'h00, 1'b1);
    wait_rsp(n);
    chk_total++;
    if ({rsp_valid, rsp_result, rsp_carry} !== {1'b1, 8'h08, 1'b0})
      $display("FAIL chain_rsp1 got %h exp %h", {rsp_valid, rsp_result, rsp_carry}, {1'b1, 8'h08, 1'b0});
    else chk_pass++;
    tick();
    wait_rsp(n);
    chk_total++;
    if ({rsp_valid, rsp_result, rsp_carry} !== {1'b1, 8'h09, 1'b0})
      $display("FAIL chain_rsp2 got %h exp %h", {rsp_valid, rsp_result, rsp_carry}, {1'b1, 8'h09, 1'b0});
    else chk_pass++;
    chk_total++;
    if (acc !== 8'h09) $display("FAIL chain_acc got %h exp 09", acc); else chk_pass++;
    tick();
  endtask

  task automatic test_zero;
    int n;
    rsp_ready = 1'b1;
    push(3'b100, 8'h6D, 8'h6D, 1'b0);
    wait_rsp(n);
    chk_total++;
    if ({rsp_valid, rsp_result, rsp_carry, rsp_zero} !== {1'b1, 8'h00, 1'b0, 1'b1})
      $display("FAIL zero_rsp got %h exp %h", {rsp_valid, rsp_result, rsp_carry, rsp_zero},
               {1'b1, 8'h00, 1'b0, 1'b1});
    else chk_pass++;
    tick();
  endtask

  task automatic test_backpressure;
    logic [2:0] op  [6] = '{3'b000, 3'b100, 3'b000, 3'b110, 3'b000, 3'b000};
    logic [7:0] av  [6] = '{8'h10, 8'hF0, 8'h80, 8'hAA, 8'h22, 8'h01};
    logic [7:0] bv  [6] = '{8'h01, 8'h0F, 8'h80, 8'h00, 8'h33, 8'h01};
    logic       af  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [7:0] res [5] = '{8'h11, 8'hFF, 8'h00, 8'h01, 8'h55};
    logic       cy  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int accepted;
    int n;
    accepted = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cmd_opcode = op[i]; cmd_a = av[i]; cmd_b = bv[i]; cmd_acc = af[i];
      cmd_valid = 1'b1;
      if (cmd_ready === 1'b1) accepted++;
      tick();
    end
    cmd_valid = 1'b0;
    chk_total++;
    if (accepted !== 5) $display("FAIL bp_accepted got %0d exp 5", accepted); else chk_pass++;
    chk_total++;
    if ({count, cmd_ready} !== {3'd4, 1'b0})
      $display("FAIL bp_full got %h exp %h", {count, cmd_ready}, {3'd4, 1'b0});
    else chk_pass++;
    for (int i = 0; i < 3; i++) begin
      chk_total++;
      if ({rsp_valid, rsp_result, rsp_carry} !== {1'b1, res[0], cy[0]})
        $display("FAIL bp_stable got %h exp %h", {rsp_valid, rsp_result, rsp_carry}, {1'b1, res[0], cy[0]});
      else chk_pass++;
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk_total++;
    if ({cmd_ready, count, rsp_valid} !== {1'b1, 3'd3, 1'b0})
      $display("FAIL bp_release got %h exp %h", {cmd_ready, count, rsp_valid}, {1'b1, 3'd3, 1'b0});
    else chk_pass++;
    for (int i = 1; i < 5; i++) begin
      wait_rsp(n);
      chk_total++;
      if ({rsp_valid, rsp_result, rsp_carry} !== {1'b1, res[i], cy[i]})
        $display("FAIL bp_rsp%0d got %h exp %h", i, {rsp_valid, rsp_result, rsp_carry}, {1'b1, res[i], cy[i]});
      else chk_pass++;
      tick();
    end
    chk_total++;
    if (count !== 3'd0) $display("FAIL bp_drained got %0d exp 0", count); else chk_pass++;
  endtask

  task automatic test_reset_mid;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(3'b000, 8'h40, 8'(i), 1'b0);
    chk_total++;
    if ({count, rsp_valid} !== {3'd3, 1'b1})
      $display("FAIL rmid_pre got %h exp %h", {count, rsp_valid}, {3'd3, 1'b1});
    else chk_pass++;
    #2 rst_n = 1'b0;
    #1;
    chk_total++;
    if ({alu_a, alu_b, alu_opcode, acc, rsp_result, rsp_carry, rsp_zero, rsp_valid} !== 38'h0)
      $display("FAIL rmid_regs got %h exp 0",
               {alu_a, alu_b, alu_opcode, acc, rsp_result, rsp_carry, rsp_zero, rsp_valid});
    else chk_pass++;
    chk_total++;
    if ({count, cmd_ready} !== {3'd0, 1'b1})
      $display("FAIL rmid_count got %h exp %h", {count, cmd_ready}, {3'd0, 1'b1});
    else chk_pass++;
    @(posedge clk);
    #4 rst_n = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk_total++;
    if ({rsp_valid, count, cmd_ready} !== {1'b0, 3'd0, 1'b1})
      $display("FAIL rmid_stale got %h exp %h", {rsp_valid, count, cmd_ready}, {1'b0, 3'd0, 1'b1});
    else chk_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] res [6] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    int n;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) push(3'b000, 8'h30 + 8'(i), 8'h01, 1'b0);
    chk_total++;
    if ({count, rsp_valid, rsp_result} !== {3'd2, 1'b1, res[0]})
      $display("FAIL b2b_pre got %h exp %h", {count, rsp_valid, rsp_result}, {3'd2, 1'b1, res[0]});
    else chk_pass++;
    rsp_ready = 1'b1;
    push(3'b000, 8'h33, 8'h01, 1'b0);
    chk_total++;
    if (count !== 3'd2) $display("FAIL b2b_count got %0d exp 2", count); else chk_pass++;
    rsp_ready = 1'b0;
    push(3'b000, 8'h34, 8'h01, 1'b0);
    push(3'b000, 8'h35, 8'h01, 1'b0);
    rsp_ready = 1'b1;
    for (int i = 1; i < 6; i++) begin
      wait_rsp(n);
      chk_total++;
      if ({rsp_valid, rsp_result} !== {1'b1, res[i]})
        $display("FAIL b2b_rsp%0d got %h exp %h", i, {rsp_valid, rsp_result}, {1'b1, res[i]});
      else chk_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_chain();
    test_zero();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
